// File: rtl/phytx_pkg.sv
// ----------------------------------------------------------------------------
// phytx_pkg
// Shared definitions for the USBPD PHY transmit FIFO and its TX-start
// sequencer: the sequencer state encoding, the default buffer depth and the
// byte constants used by the data path.
// ----------------------------------------------------------------------------
package phytx_pkg;

    // Gray-ordered so every legal transition flips exactly one state bit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_BUSY = 2'd3,
        ST_DONE = 2'd2
    } phytx_state_e;

    // Default depth matches the PHY's 5-bit byte counter.
    localparam int PHYTX_DEPTH = 32;

    // Byte software loads to send a zero-payload frame.
    localparam logic [7:0] PHYTX_ZLP_BYTE = 8'h00;

    // Value presented on the head-byte output while the buffer is empty.
    localparam logic [7:0] PHYTX_EMPTY_RDAT = 8'h00;

endpackage : phytx_pkg

// File: rtl/phytx_fifo_mem.sv
// ----------------------------------------------------------------------------
// phytx_fifo_mem
// DEPTH x 8 storage array for the PHY transmit FIFO. Synchronous write port,
// asynchronous (show-ahead) read port. The array is intentionally not reset;
// the read side is qualified by the occupancy count in the parent.
//
// Ports:
//   clk      in   clock, write on rising edge
//   we_i     in   write enable
//   waddr_i  in   AW  write address
//   wdata_i  in   8   write data
//   raddr_i  in   AW  read address
//   rdata_o  out  8   array contents at raddr_i
// ----------------------------------------------------------------------------
module phytx_fifo_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];

    // Write port: store one byte per enabled cycle.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule : phytx_fifo_mem

// File: rtl/phytx_fifo.sv
// ----------------------------------------------------------------------------
// phytx_fifo
// Transmit byte FIFO and TX-start sequencer feeding the USBPD PHY transmitter.
// Software pushes payload/K-code bytes; the PHY reads the show-ahead head byte
// plus a last-byte flag and pops as it serialises. A four-state sequencer turns
// a software "go" into a single-cycle TX request and reports completion when
// the PHY signals end of frame.
//
// Optional feature macro: PHYTX_FIFO_ERRFLAG_EN adds the sticky o_ovf/o_udf
// flags. Without it, overflow pushes are dropped and underflow pops ignored
// silently.
//
// Ports:
//   clk        in   clock
//   srstz      in   asynchronous active-low reset
//   i_wr       in   push strobe
//   i_wdat     in   8   push data
//   i_clr      in   flush pointers, count and error flags
//   i_txgo     in   software start pulse
//   i_pop      in   pop strobe from the PHY
//   i_goidle   in   PHY end-of-frame pulse
//   o_rdat     out  8   head byte (8'h00 when empty)
//   o_one      out  exactly one byte queued (PHY last-byte)
//   o_empty    out  buffer empty
//   o_full     out  buffer full
//   o_cnt      out  AW+1 occupancy
//   o_txreq    out  one-cycle TX request
//   o_busy     out  frame in progress
//   o_done     out  one-cycle completion pulse
//   o_ovf      out  sticky overflow (macro only)
//   o_udf      out  sticky underflow (macro only)
// ----------------------------------------------------------------------------
module phytx_fifo
    import phytx_pkg::*;
#(
    parameter int DEPTH = PHYTX_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          srstz,
    input  logic          i_wr,
    input  logic [7:0]    i_wdat,
    input  logic          i_clr,
    input  logic          i_txgo,
    input  logic          i_pop,
    input  logic          i_goidle,
    output logic [7:0]    o_rdat,
    output logic          o_one,
    output logic          o_empty,
    output logic          o_full,
    output logic [AW:0]   o_cnt,
    output logic          o_txreq,
    output logic          o_busy,
    output logic          o_done
`ifdef PHYTX_FIFO_ERRFLAG_EN
    ,
    output logic          o_ovf,
    output logic          o_udf
`endif
);

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW:0]   cnt_q, cnt_d;
    phytx_state_e  state_q, state_d;

    logic          empty_s;
    logic          full_s;
    logic          pop_ok_s;
    logic          push_ok_s;
    logic          mem_we_s;
    logic [7:0]    mem_rdata_s;

    assign empty_s   = (cnt_q == '0);
    assign full_s    = (cnt_q == CNT_FULL);
    assign pop_ok_s  = i_pop & ~empty_s;
    // A push at full is still taken when a pop frees the head slot this cycle.
    assign push_ok_s = i_wr & (~full_s | pop_ok_s);
    assign mem_we_s  = push_ok_s & ~i_clr;

    phytx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we_s),
        .waddr_i (wp_q),
        .wdata_i (i_wdat),
        .raddr_i (rp_q),
        .rdata_o (mem_rdata_s)
    );

    // Pointer and occupancy next-state; flush overrides push and pop.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (i_clr) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok_s) begin
                wp_d = wp_q + PTR_ONE;
            end else begin
                wp_d = wp_q;
            end
            if (pop_ok_s) begin
                rp_d = rp_q + PTR_ONE;
            end else begin
                rp_d = rp_q;
            end
            if (push_ok_s && !pop_ok_s) begin
                cnt_d = cnt_q + CNT_ONE;
            end else if (pop_ok_s && !push_ok_s) begin
                cnt_d = cnt_q - CNT_ONE;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // Sequencer next-state; the flush input deliberately does not touch it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_txgo && !empty_s) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ:  state_d = ST_BUSY;
            ST_BUSY: begin
                if (i_goidle) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef PHYTX_FIFO_ERRFLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags; flush clears them ahead of any set term.
    always_comb begin
        ovf_d = ovf_q;
        udf_d = udf_q;
        if (i_clr) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end else begin
            ovf_d = ovf_q | (i_wr & full_s & ~pop_ok_s);
            udf_d = udf_q | (i_pop & empty_s);
        end
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge srstz) begin
        if (!srstz) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_ovf = ovf_q;
    assign o_udf = udf_q;
`endif

    // All outputs decode from registered state only.
    assign o_rdat  = empty_s ? PHYTX_EMPTY_RDAT : mem_rdata_s;
    assign o_one   = (cnt_q == CNT_ONE);
    assign o_empty = empty_s;
    assign o_full  = full_s;
    assign o_cnt   = cnt_q;
    assign o_txreq = (state_q == ST_REQ);
    assign o_busy  = (state_q == ST_REQ) || (state_q == ST_BUSY);
    assign o_done  = (state_q == ST_DONE);

endmodule : phytx_fifo

// File: doc/phytx_fifo.md
# phytx_fifo

Transmit byte FIFO and TX-start sequencer placed directly upstream of the USBPD PHY transmitter. Register/MCU writes load payload bytes, K-code bytes and the zero-payload marker into a circular buffer. The transmitter reads the show-ahead head byte together with a last-byte flag, and pops entries as it serialises them. A small FSM converts a software "go" into the single-cycle TX request and reports completion when the PHY returns to idle.

## Interface
- DEPTH, 32: number of byte entries; power of two, 2..32; matches the PHY's 5-bit byte counter.
- AW, $clog2(DEPTH): pointer width; the count is AW+1 bits.
- clk  in  1  single clock, all state on rising edge.
- srstz  in  1  reset; asynchronous, active-low.
- i_wr  in  1  push strobe, one byte per cycle.
- i_wdat  in  8  push data.
- i_clr  in  1  flush: pointers, count and error flags to zero.
- i_txgo  in  1  software start pulse.
- i_pop  in  1  pop strobe from the PHY fifo-pop output.
- i_goidle  in  1  PHY end-of-frame pulse.
- o_rdat  out  8  head byte; 8'h00 when empty.
- o_one  out  1  count==1; drives the PHY last-byte input.
- o_empty / o_full  out  1 each  status.
- o_cnt  out  AW+1  occupancy, 0..DEPTH.
- o_txreq  out  1  one-cycle TX request to the PHY.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle completion pulse.
- o_ovf / o_udf  out  1 each  sticky error flags; present only with the macro.

## Operation
- Storage is a DEPTH x 8 register array with write pointer wp, read pointer rp and counter cnt.
- Both pointers wrap modulo DEPTH (natural AW-bit wrap).
- Push is accepted when i_wr and ~o_full, or when i_wr, o_full and an accepted pop occur in the same cycle.
- Pop is accepted when i_pop and ~o_empty.
- Push and pop in the same cycle: cnt unchanged, both pointers advance.
- Push while full with no pop: byte dropped, nothing changes, o_ovf set.
- Pop while empty: ignored, o_udf set.
- i_clr has priority over push, pop and the flag set terms in the same cycle. The FSM is not affected.
- o_rdat = mem[rp] when cnt!=0, else 8'h00. There is no read latency.
- o_one, o_empty, o_full and o_cnt are decoded from registered cnt.
- FSM states and transitions:
  - IDLE -> REQ on i_txgo & ~o_empty. An i_txgo while empty is ignored; the FSM stays in IDLE.
  - REQ -> BUSY unconditionally. o_txreq = 1 in REQ only.
  - BUSY -> DONE on i_goidle.
  - DONE -> IDLE unconditionally. o_done = 1 in DONE only.
- o_busy = REQ | BUSY.
- i_txgo in any state other than IDLE is ignored.
- i_goidle outside BUSY is ignored.
- Pushes are allowed in every state; software may stream bytes while a frame is in progress.
- Zero-payload frames need one 8'h00 byte loaded. The PHY pops it through its empty-pop path.
- i_clr during BUSY empties the buffer. The frame still ends on i_goidle; any further PHY pops flag o_udf.

## Timing
- Reset values: wp=rp=cnt=0; FSM=IDLE.
- Output values under reset: o_rdat=0, o_one=0, o_empty=1, o_full=0, o_cnt=0, o_txreq=0, o_busy=0, o_done=0, o_ovf=0, o_udf=0.
- Push at edge N: the byte is visible on o_rdat after edge N if the FIFO was empty. cnt updates at edge N.
- Pop at edge N: the next byte is on o_rdat right after edge N. The PHY samples it from cycle N+1, which meets the PHY bit-counter restart.
- i_txgo registered at edge N: REQ during cycle N+1, and o_txreq is high for exactly that cycle. BUSY follows from N+2.
- i_goidle at edge M: o_done is high during cycle M+1, and o_busy is already low in that cycle.
- The minimum frame-to-frame turnaround is 3 cycles from i_goidle to the next o_txreq.
- All outputs are registered or decoded only from registers. There is no combinational path from any input to any output.

## Configuration
- Macro: PHYTX_FIFO_ERRFLAG_EN.
- Defined: o_ovf and o_udf ports exist. They are sticky, cleared only by i_clr or reset, with set and clear behaviour as described above.
- Undefined: the ports and flag flops are removed. Overflow pushes are still dropped silently and underflow pops still ignored, so FIFO behaviour is otherwise identical.

## Structure
- Shared package phytx_pkg holds:
  - the FSM state enum: IDLE=2'd0, REQ=2'd1, BUSY=2'd3, DONE=2'd2 (Gray order);
  - the DEPTH default;
  - the zero-payload marker constant 8'h00.
- One sub-module, phytx_fifo_mem: the DEPTH x 8 array with a synchronous write port and an asynchronous read port, no reset.
- Pointers, counter, flags and FSM live in phytx_fifo.

## Test plan
- Reset, then push 8'hA1, 8'hB2 -> o_cnt=2, o_rdat=8'hA1, o_one=0. Pop once -> o_rdat=8'hB2, o_one=1. Pop again -> o_empty=1, o_rdat=8'h00.
- Fill 32 bytes 0..31 -> o_full=1. Push 8'hFF -> dropped, o_ovf=1. Pop 32 times -> bytes read back 0..31 in order, the wrap is seamless.
- At full, push 8'h55 and pop in the same cycle -> o_cnt stays 32, 8'h55 becomes the last entry, o_ovf unchanged.
- Load 3 bytes, pulse i_txgo -> o_txreq high for exactly one cycle, o_busy high. i_goidle 40 cycles later -> o_done one cycle later, FSM returns to IDLE.
- i_txgo with the FIFO empty -> no o_txreq, FSM stays IDLE. A second i_txgo while BUSY -> ignored.
- i_clr during BUSY with 4 bytes queued -> o_cnt=0. Subsequent i_pop -> o_udf=1 (macro defined). i_goidle still produces o_done.
